// File: rtl/cpl_timeout_sched_if.sv
// Request/completion/timeout-event bundle between the transaction layer and
// the completion-timeout scheduler.
interface cpl_timeout_sched_if #(
  parameter int unsigned TAG_W = 3
);
  logic             alloc_valid;
  logic [TAG_W-1:0] alloc_tag;
  logic             cpl_valid;
  logic [TAG_W-1:0] cpl_tag;
  logic             to_valid;
  logic [TAG_W-1:0] to_tag;
  logic             to_ready;

  modport master (
    output alloc_valid, alloc_tag, cpl_valid, cpl_tag, to_ready,
    input  to_valid, to_tag
  );

  modport slave (
    input  alloc_valid, alloc_tag, cpl_valid, cpl_tag, to_ready,
    output to_valid, to_tag
  );
endinterface

// File: rtl/cpl_timeout_sched.sv
// Completion-timeout scheduler: timestamps outstanding non-posted tags against
// a shared free-running timer and reports expired tags one at a time.
module cpl_timeout_sched #(
  parameter int unsigned TAGS  = 8,
  parameter int unsigned TAG_W = 3,
  parameter int unsigned WIDTH = 44
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     timer,
  output logic                 timer_sync_rst,
  input  logic                 timeout_en,
  input  logic [WIDTH-1:0]     timeout_limit,
  cpl_timeout_sched_if.slave   bus,
  output logic [TAG_W:0]       outstanding,
  output logic                 dup_alloc_err,
  output logic                 unexp_cpl_err
);

  localparam int unsigned CNT_W = TAG_W + 1;

  typedef enum logic {
    EV_IDLE = 1'b0,
    EV_PEND = 1'b1
  } ev_state_e;

  ev_state_e        ev_q, ev_d;
  logic [TAG_W-1:0] to_tag_q, to_tag_d;

  logic [TAGS-1:0]  valid_q, valid_d;
  logic [WIDTH-1:0] stamp_q [TAGS];
  logic [TAG_W-1:0] scan_ptr_q;
  logic [CNT_W-1:0] outstanding_d;
  logic             armed_q;

  logic             stall;
  logic             scan_en;
  logic [WIDTH-1:0] elapsed;
  logic             expired;
  logic             scan_hit;
  logic             detect;
  logic             cpl_same;
  logic             cpl_free;
  logic             alloc_new;
  logic             dup_d;
  logic             unexp_d;
  logic             clr_d;
  logic [WIDTH-1:0] alloc_stamp;

  // Slot bookkeeping and scanner decision for the current cycle
  always_comb begin
    stall     = (ev_q == EV_PEND) && !bus.to_ready;
    scan_en   = timeout_en && !stall;
    elapsed   = timer - stamp_q[scan_ptr_q];
    expired   = (elapsed >= timeout_limit);
    scan_hit  = (bus.cpl_valid && (bus.cpl_tag == scan_ptr_q)) ||
                (bus.alloc_valid && (bus.alloc_tag == scan_ptr_q));
    detect    = scan_en && valid_q[scan_ptr_q] && expired && !scan_hit;

    cpl_same  = bus.cpl_valid && bus.alloc_valid && (bus.cpl_tag == bus.alloc_tag);
    cpl_free  = bus.cpl_valid && valid_q[bus.cpl_tag];
    alloc_new = bus.alloc_valid && (!valid_q[bus.alloc_tag] || cpl_same);
    dup_d     = bus.alloc_valid && valid_q[bus.alloc_tag] && !cpl_same;
    unexp_d   = bus.cpl_valid && !valid_q[bus.cpl_tag];

    valid_d = valid_q;
    if (detect)          valid_d[scan_ptr_q]    = 1'b0;
    if (bus.cpl_valid)   valid_d[bus.cpl_tag]   = 1'b0;
    if (bus.alloc_valid) valid_d[bus.alloc_tag] = 1'b1;

    outstanding_d = outstanding + CNT_W'(alloc_new) - CNT_W'(cpl_free) - CNT_W'(detect);

    clr_d = armed_q && (outstanding == '0) && !bus.alloc_valid && timer_sync_rst;

    // The timer reads zero next cycle while its clear is applied, so stamp to match
    alloc_stamp = timer_sync_rst ? timer : '0;
  end

  // Timeout event channel: next-state and payload
  always_comb begin
    ev_d     = ev_q;
    to_tag_d = to_tag_q;
    unique case (ev_q)
      EV_IDLE: begin
        if (detect) begin
          ev_d     = EV_PEND;
          to_tag_d = scan_ptr_q;
        end
      end
      EV_PEND: begin
        if (bus.to_ready) begin
          if (detect) begin
            ev_d     = EV_PEND;
            to_tag_d = scan_ptr_q;
          end else begin
            ev_d = EV_IDLE;
          end
        end
      end
      default: ev_d = EV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_q     <= EV_IDLE;
      to_tag_q <= '0;
    end else begin
      ev_q     <= ev_d;
      to_tag_q <= to_tag_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q        <= '0;
      scan_ptr_q     <= '0;
      outstanding    <= '0;
      dup_alloc_err  <= 1'b0;
      unexp_cpl_err  <= 1'b0;
      timer_sync_rst <= 1'b1;
      armed_q        <= 1'b0;
      for (int i = 0; i < int'(TAGS); i++) begin
        stamp_q[i] <= '0;
      end
    end else begin
      valid_q        <= valid_d;
      outstanding    <= outstanding_d;
      dup_alloc_err  <= dup_d;
      unexp_cpl_err  <= unexp_d;
      timer_sync_rst <= !clr_d;
      if (scan_en) begin
        scan_ptr_q <= scan_ptr_q + TAG_W'(1);
      end
      if (bus.alloc_valid) begin
        stamp_q[bus.alloc_tag] <= alloc_stamp;
        armed_q                <= 1'b1;
      end else if (clr_d) begin
        armed_q <= 1'b0;
      end
    end
  end

  assign bus.to_valid = (ev_q == EV_PEND);
  assign bus.to_tag   = to_tag_q;

endmodule

// File: tb/tb_cpl_timeout_sched.sv
// Directed bench for cpl_timeout_sched with a local Timer model.
module tb_cpl_timeout_sched;

  localparam int unsigned TAGS  = 8;
  localparam int unsigned TAG_W = 3;
  localparam int unsigned WIDTH = 44;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] timer;
  logic             timer_sync_rst;
  logic             timeout_en;
  logic [WIDTH-1:0] timeout_limit;
  logic [TAG_W:0]   outstanding;
  logic             dup_alloc_err;
  logic             unexp_cpl_err;

  logic             load;
  logic [WIDTH-1:0] load_val;

  int n_checks;
  int n_errors;

  cpl_timeout_sched_if #(.TAG_W(TAG_W)) bus ();

  cpl_timeout_sched #(.TAGS(TAGS), .TAG_W(TAG_W), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .timer          (timer),
    .timer_sync_rst (timer_sync_rst),
    .timeout_en     (timeout_en),
    .timeout_limit  (timeout_limit),
    .bus            (bus),
    .outstanding    (outstanding),
    .dup_alloc_err  (dup_alloc_err),
    .unexp_cpl_err  (unexp_cpl_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer model: free-running, synchronous active-low clear, preload for wrap tests
  always @(posedge clk or negedge rst) begin
    if (!rst)                 timer <= '0;
    else if (load)            timer <= load_val;
    else if (!timer_sync_rst) timer <= '0;
    else                      timer <= timer + WIDTH'(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_event(input int max_cyc, output bit seen, output logic [WIDTH-1:0] t_seen,
                            output logic [TAG_W-1:0] tag_seen, output logic [TAG_W:0] out_seen);
    seen = 1'b0; t_seen = '0; tag_seen = '0; out_seen = '0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      if (bus.to_valid) begin
        seen = 1'b1; t_seen = timer; tag_seen = bus.to_tag; out_seen = outstanding;
      end
    end
  endtask

  task automatic count_events(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.to_valid) cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  bit               seen;
  logic [WIDTH-1:0] t_seen;
  logic [WIDTH-1:0] t_ref;
  logic [TAG_W-1:0] tag_seen;
  logic [TAG_W:0]   out_seen;
  int               cnt;
  int               lows;
  int               bad;
  int               tags_q [$];

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b0; load = 1'b0; load_val = '0;
    timeout_en = 1'b0; timeout_limit = WIDTH'(16);
    bus.alloc_valid = 1'b0; bus.alloc_tag = '0;
    bus.cpl_valid = 1'b0; bus.cpl_tag = '0; bus.to_ready = 1'b1;
    tick(); tick();
    check("rst_to_valid", 64'(bus.to_valid), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_timer_clr", 64'(timer_sync_rst), 64'd1);
    check("rst_dup", 64'(dup_alloc_err), 64'd0);
    check("rst_unexp", 64'(unexp_cpl_err), 64'd0);
    rst = 1'b1;
    timeout_en = 1'b1;

    // Expiry of tag 3 stamped at timer=100, limit 16
    for (int i = 0; i < 200 && timer != WIDTH'(100); i++) tick();
    check("exp_timer_reached", 64'(timer), 64'd100);
    bus.alloc_valid = 1'b1; bus.alloc_tag = 3'd3;
    tick();
    bus.alloc_valid = 1'b0;
    check("exp_out_1", 64'(outstanding), 64'd1);
    wait_event(40, seen, t_seen, tag_seen, out_seen);
    check("exp_seen", 64'(seen), 64'd1);
    check("exp_tag", 64'(tag_seen), 64'd3);
    check("exp_window", 64'((t_seen >= WIDTH'(117)) && (t_seen <= WIDTH'(124))), 64'd1);
    check("exp_out_0", 64'(out_seen), 64'd0);
    tick();
    check("exp_drop", 64'(bus.to_valid), 64'd0);
    lows = timer_sync_rst ? 0 : 1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (!timer_sync_rst) lows++;
    end
    check("exp_clr_pulses", 64'(lows), 64'd1);
    check("exp_timer_cleared", 64'(timer < WIDTH'(12)), 64'd1);

    // Completion 10 cycles after issue beats a 16-cycle limit
    bus.alloc_valid = 1'b1; bus.alloc_tag = 3'd5;
    tick();
    bus.alloc_valid = 1'b0;
    count_events(9, cnt);
    bus.cpl_valid = 1'b1; bus.cpl_tag = 3'd5;
    tick();
    bus.cpl_valid = 1'b0;
    check("cpl_unexp_0", 64'(unexp_cpl_err), 64'd0);
    check("cpl_out_0", 64'(outstanding), 64'd0);
    count_events(10, bad);
    check("cpl_no_event", 64'(cnt + bad), 64'd0);
    bus.cpl_valid = 1'b1; bus.cpl_tag = 3'd5;
    tick();
    bus.cpl_valid = 1'b0;
    check("cpl_unexp_pulse", 64'(unexp_cpl_err), 64'd1);
    tick();
    check("cpl_unexp_clear", 64'(unexp_cpl_err), 64'd0);

    // Backpressure: tags 0..2 expire, consumer stalls 20 cycles
    do_reset();
    timeout_en = 1'b0; bus.to_ready = 1'b0; timeout_limit = WIDTH'(4);
    for (int t = 0; t < 3; t++) begin
      bus.alloc_valid = 1'b1; bus.alloc_tag = TAG_W'(t);
      tick();
    end
    bus.alloc_valid = 1'b0;
    check("bp_out_3", 64'(outstanding), 64'd3);
    for (int i = 0; i < 6; i++) tick();
    timeout_en = 1'b1;
    tick();
    check("bp_valid", 64'(bus.to_valid), 64'd1);
    check("bp_tag0", 64'(bus.to_tag), 64'd0);
    check("bp_out_2", 64'(outstanding), 64'd2);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.to_valid || bus.to_tag != 3'd0 || outstanding != 4'd2) bad++;
    end
    check("bp_hold", 64'(bad), 64'd0);
    bus.to_ready = 1'b1;
    tags_q.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.to_valid) tags_q.push_back(int'(bus.to_tag));
    end
    check("bp_count", 64'(tags_q.size()), 64'd2);
    if (tags_q.size() == 2) begin
      check("bp_first", 64'(tags_q[0]), 64'd1);
      check("bp_second", 64'(tags_q[1]), 64'd2);
    end
    check("bp_out_end", 64'(outstanding), 64'd0);

    // Wrap: stamp 2^WIDTH-4, limit 8, expires once timer reaches 4
    do_reset();
    timeout_limit = WIDTH'(8);
    load = 1'b1; load_val = {WIDTH{1'b1}} - WIDTH'(3);
    tick();
    load = 1'b0;
    bus.alloc_valid = 1'b1; bus.alloc_tag = 3'd4;
    tick();
    bus.alloc_valid = 1'b0;
    wait_event(30, seen, t_seen, tag_seen, out_seen);
    check("wrap_seen", 64'(seen), 64'd1);
    check("wrap_tag", 64'(tag_seen), 64'd4);
    check("wrap_window", 64'((t_seen >= WIDTH'(5)) && (t_seen <= WIDTH'(12))), 64'd1);

    // Collisions: duplicate alloc, then alloc+cpl restamp
    timeout_limit = WIDTH'(1000);
    bus.alloc_valid = 1'b1; bus.alloc_tag = 3'd2;
    tick();
    check("dup_first_0", 64'(dup_alloc_err), 64'd0);
    tick();
    check("dup_pulse", 64'(dup_alloc_err), 64'd1);
    check("dup_out_1", 64'(outstanding), 64'd1);
    bus.alloc_valid = 1'b0;
    tick();
    check("dup_clear", 64'(dup_alloc_err), 64'd0);
    for (int i = 0; i < 30; i++) tick();
    bus.alloc_valid = 1'b1; bus.alloc_tag = 3'd2;
    bus.cpl_valid = 1'b1; bus.cpl_tag = 3'd2;
    t_ref = timer;
    tick();
    bus.alloc_valid = 1'b0; bus.cpl_valid = 1'b0;
    check("same_dup_0", 64'(dup_alloc_err), 64'd0);
    check("same_unexp_0", 64'(unexp_cpl_err), 64'd0);
    check("same_out_1", 64'(outstanding), 64'd1);
    timeout_limit = WIDTH'(20);
    wait_event(40, seen, t_seen, tag_seen, out_seen);
    check("same_seen", 64'(seen), 64'd1);
    check("same_tag", 64'(tag_seen), 64'd2);
    check("same_restamp", 64'((t_seen >= t_ref + WIDTH'(21)) && (t_seen <= t_ref + WIDTH'(28))), 64'd1);

    // Completion lands on the same cycle the scanner would report tag 0
    do_reset();
    timeout_en = 1'b0; timeout_limit = WIDTH'(4);
    bus.alloc_valid = 1'b1; bus.alloc_tag = 3'd0;
    tick();
    bus.alloc_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    timeout_en = 1'b1;
    bus.cpl_valid = 1'b1; bus.cpl_tag = 3'd0;
    tick();
    bus.cpl_valid = 1'b0;
    check("race_unexp_0", 64'(unexp_cpl_err), 64'd0);
    check("race_out_0", 64'(outstanding), 64'd0);
    count_events(12, cnt);
    check("race_no_event", 64'(cnt), 64'd0);

    // Reset while an event is stalled
    do_reset();
    timeout_en = 1'b0; bus.to_ready = 1'b0; timeout_limit = WIDTH'(4);
    bus.alloc_valid = 1'b1; bus.alloc_tag = 3'd1;
    tick();
    bus.alloc_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    timeout_en = 1'b1;
    wait_event(10, seen, t_seen, tag_seen, out_seen);
    check("rs_seen", 64'(seen), 64'd1);
    check("rs_tag", 64'(tag_seen), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rs_to_valid", 64'(bus.to_valid), 64'd0);
    check("rs_out", 64'(outstanding), 64'd0);
    tick();
    rst = 1'b1; bus.to_ready = 1'b1;
    count_events(15, cnt);
    check("rs_no_event", 64'(cnt), 64'd0);
    bus.cpl_valid = 1'b1; bus.cpl_tag = 3'd1;
    tick();
    bus.cpl_valid = 1'b0;
    check("rs_unexp", 64'(unexp_cpl_err), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpl_timeout_sched.md
Name: cpl_timeout_sched

Overview:
- Completion-timeout scheduler for non-posted requests in the transaction layer.
- Shares one free-running Timer counter across TAGS outstanding request tags.
- Timestamps each tag on issue and frees it on completion.
- Scans tags round-robin, one per cycle, and reports expired tags over a valid/ready interface.
- Drives the Timer's active-low synchronous clear so the counter restarts whenever nothing is outstanding.

Parameters:
TAGS, 8, number of tracked tags (power of 2, at least 2)
TAG_W, 3, log2(TAGS)
WIDTH, 44, timer/timestamp width (matches Timer WIDTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
timer  in  WIDTH  current Timer count
timer_sync_rst  out  1  to Timer sync_rst; active-low synchronous clear
timeout_en  in  1  1 = scanning enabled
timeout_limit  in  WIDTH  elapsed-cycle threshold; quasi-static config
alloc_valid  in  1  non-posted request issued this cycle
alloc_tag  in  TAG_W  tag of issued request
cpl_valid  in  1  final completion received this cycle
cpl_tag  in  TAG_W  tag of completion
to_valid  out  1  timeout event pending
to_tag  out  TAG_W  tag that timed out
to_ready  in  1  consumer accepts timeout event
outstanding  out  TAG_W+1  count of valid slots
dup_alloc_err  out  1  one-cycle pulse: alloc to an already-valid slot
unexp_cpl_err  out  1  one-cycle pulse: cpl to an invalid slot

Behaviour:
- Reset (rst low, asynchronous) clears the following:
  - all slot valid bits and stamps to 0
  - scan_ptr to 0
  - to_valid, to_tag, outstanding, dup_alloc_err, unexp_cpl_err to 0
  - timer_sync_rst to 1
- Per-slot state: valid bit plus stamp[WIDTH-1:0].
- Alloc:
  - Sets valid[alloc_tag] and sets stamp to the current timer value, effective next cycle.
  - If the slot is already valid and not freed by a cpl in the same cycle: pulse dup_alloc_err; slot is re-stamped (restart).
- Cpl:
  - Clears valid[cpl_tag].
  - If the slot is invalid: pulse unexp_cpl_err, no state change.
- Alloc and cpl on the same tag in the same cycle: cpl frees, then alloc re-stamps. Slot ends valid, no error.
- Elapsed time = (timer - stamp) mod 2^WIDTH. Wrap-around is handled by the modular subtraction.
- Expiry condition: elapsed >= timeout_limit.
- Scanner:
  - Advances only while timeout_en=1 and no event is stalled.
  - Each cycle, evaluates slot[scan_ptr] and then increments scan_ptr mod TAGS.
  - If the slot is valid, expired, and not hit by cpl_valid or alloc_valid this cycle: register to_valid=1, to_tag=scan_ptr, and clear the slot.
- Output handshake:
  - to_valid/to_tag hold stable until to_valid && to_ready. to_valid drops the cycle after acceptance.
  - While to_valid=1 && to_ready=0: scan_ptr holds and no new detection occurs.
  - At acceptance, a new detection may be registered in the same cycle (back-to-back events).
- A cpl on a timed-out (already freed) tag pulses unexp_cpl_err.
- Worst-case detection latency after expiry: TAGS cycles plus any stall time. Event visible 1 cycle after the detecting scan.
- timeout_en=0: scanner frozen, scan_ptr holds, slots still update. A pending to_valid is still presented.
- outstanding: registered, updated together with the valid bits. +1 per new alloc, -1 per cpl free or timeout free. Net change is applied when events coincide.
- Timer clear:
  - timer_sync_rst is driven low for exactly one cycle when outstanding==0, alloc_valid=0, and no clear was issued on the previous cycle.
  - It stays high thereafter until the condition re-arises after a new alloc.
  - This bounds timer growth and avoids wrap with few outstanding tags.
- timeout_limit=0: every valid slot expires at its next scan.
- Reset mid-operation discards all tags and any pending event with no output.

Test Plan:
- Expiry: limit=16, timer counting from 0, alloc tag 3 at timer=100, no cpl → to_valid with to_tag=3 once timer ≥116, within 8 cycles of that point. Then outstanding=0 and one timer_sync_rst low pulse.
- Completion before expiry: limit=16, alloc tag 5, cpl tag 5 at elapsed=10 → no to_valid, outstanding returns 0. Later cpl tag 5 → unexp_cpl_err pulse.
- Backpressure: allocs on tags 0,1,2 at the same time, limit=4, to_ready=0 for 20 cycles → to_tag=0 held stable, scan_ptr frozen. Release to_ready → tags 1 and 2 reported in order, outstanding 3→0.
- Wrap: stamp 2^WIDTH-4 (timer preloaded via reset MSB=1 path or forced), limit=8 → expiry at timer=4 after wrap.
- Collisions:
  - alloc tag 2 twice → dup_alloc_err pulse, outstanding=1.
  - alloc+cpl tag 2 in the same cycle → no error, slot valid with new stamp.
  - cpl in the same cycle the scanner detects expiry → no event.
- Reset mid-stall: to_valid=1 pending, assert rst → to_valid=0, outstanding=0 immediately. No event after release.
